// File: rtl/door_pkg.sv
// door_pkg: shared state encoding, direction type and state_o codes for the door supervisor
package door_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        AT_TOP  = 3'd1,
        AT_BOT  = 3'd2,
        MOVE_UP = 3'd3,
        MOVE_DN = 3'd4,
        STOPPED = 3'd5,
        PAUSE   = 3'd6,
        FAULT   = 3'd7
    } state_t;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } dir_t;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_AT_TOP  = 3'd1;
    localparam logic [2:0] ST_AT_BOT  = 3'd2;
    localparam logic [2:0] ST_MOVE_UP = 3'd3;
    localparam logic [2:0] ST_MOVE_DN = 3'd4;
    localparam logic [2:0] ST_STOPPED = 3'd5;
    localparam logic [2:0] ST_PAUSE   = 3'd6;
    localparam logic [2:0] ST_FAULT   = 3'd7;

endpackage

// File: rtl/door_supervisor_if.sv
// door_if: board-side pins of the door supervisor (raw inputs in, motor driver pins out)
interface door_if;

    logic       btn_wall;
    logic       btn_remote;
    logic       obstruct;
    logic       up_limit;
    logic       dn_limit;
    logic       fault_clr;
    logic       motor_up;
    logic       motor_dn;
    logic       fault;
    logic [2:0] state_o;

    modport master (
        output btn_wall, btn_remote, obstruct, up_limit, dn_limit, fault_clr,
        input  motor_up, motor_dn, fault, state_o
    );

    modport slave (
        input  btn_wall, btn_remote, obstruct, up_limit, dn_limit, fault_clr,
        output motor_up, motor_dn, fault, state_o
    );

endinterface

// File: rtl/door_debounce.sv
// door_debounce: 2-flop sync, DEB_CYC consecutive-high qualifier, one pulse per press
module door_debounce #(
    parameter int DEB_CYC = 4,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic             press_q, press_d;

    // Count consecutive high cycles; fire once, then stay quiet until the level drops
    always_comb begin
        press_d = sync_q[1] && !fired_q && (cnt_q == DEB_LAST);
        fired_d = sync_q[1] && (fired_q || press_d);
        cnt_d   = (!sync_q[1] || fired_q || press_d) ? '0 : cnt_q + 1'b1;
    end

    // Synchronizer and qualifier state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            fired_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/door_supervisor.sv
// door_supervisor: garage-door motor sequencer with limits, obstruction reverse, timeout and fault latch
// Optional auto-close from the top position is enabled by defining DOOR_AUTO_CLOSE_EN.
module door_supervisor
    import door_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 1000,
    parameter int DEB_CYC        = 4,
    parameter int REV_PAUSE      = 8,
    parameter int AUTO_CLOSE_CYC = 500,
    parameter int CNT_W          = 16
) (
    input logic   clk,
    input logic   rst,
    door_if.slave pins_io
);

`ifdef DOOR_AUTO_CLOSE_EN
    localparam bit AC_EN = 1'b1;
`else
    localparam bit AC_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] REV_LAST = CNT_W'(REV_PAUSE - 1);
    localparam logic [CNT_W-1:0] AC_LAST  = CNT_W'(AUTO_CLOSE_CYC - 1);

    logic [1:0]       up_s, dn_s, obs_s, clr_s;
    logic             wall_p, remote_p, req;
    logic             up, dn, obs, clr, count_en;
    state_t           state_q, state_d;
    dir_t             last_dir_q, last_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             motor_up_q, motor_dn_q, fault_q;

    door_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_wall (
        .clk(clk), .rst(rst), .btn_i(pins_io.btn_wall), .press_o(wall_p)
    );

    door_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_remote (
        .clk(clk), .rst(rst), .btn_i(pins_io.btn_remote), .press_o(remote_p)
    );

    // Sensor synchronizers run through reset so INIT sees true limit levels on release
    always_ff @(posedge clk) begin
        up_s  <= {up_s[0], pins_io.up_limit};
        dn_s  <= {dn_s[0], pins_io.dn_limit};
        obs_s <= {obs_s[0], pins_io.obstruct};
        clr_s <= {clr_s[0], pins_io.fault_clr};
    end

    assign up  = up_s[1];
    assign dn  = dn_s[1];
    assign obs = obs_s[1];
    assign clr = clr_s[1];
    assign req = wall_p || remote_p;

    // Next-state, travel direction memory and shared timer
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        case (state_q)
            INIT: begin
                state_d    = (up && dn) ? FAULT : up ? AT_TOP : dn ? AT_BOT : STOPPED;
                last_dir_d = DN;
            end
            AT_TOP:  state_d = (req || (AC_EN && !obs && cnt_q == AC_LAST)) ? MOVE_DN : AT_TOP;
            AT_BOT:  state_d = req ? MOVE_UP : AT_BOT;
            MOVE_DN: begin
                state_d    = dn ? AT_BOT : obs ? PAUSE : (cnt_q == TO_LAST) ? FAULT : req ? STOPPED : MOVE_DN;
                last_dir_d = (!dn && !obs && cnt_q != TO_LAST && req) ? DN : last_dir_q;
            end
            MOVE_UP: begin
                state_d    = up ? AT_TOP : (cnt_q == TO_LAST) ? FAULT : req ? STOPPED : MOVE_UP;
                last_dir_d = (!up && cnt_q != TO_LAST && req) ? UP : last_dir_q;
            end
            STOPPED: state_d = !req ? STOPPED : (last_dir_q == UP) ? MOVE_DN : MOVE_UP;
            PAUSE:   state_d = (cnt_q == REV_LAST) ? MOVE_UP : PAUSE;
            FAULT:   state_d = clr ? INIT : FAULT;
            default: state_d = INIT;
        endcase
        count_en = (state_q inside {MOVE_UP, MOVE_DN, PAUSE}) || (AC_EN && state_q == AT_TOP && !obs);
        cnt_d    = (state_d == state_q && count_en) ? cnt_q + 1'b1 : '0;
    end

    // State register and outputs decoded from next state so pins change with state_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            last_dir_q <= DN;
            cnt_q      <= '0;
            motor_up_q <= 1'b0;
            motor_dn_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            cnt_q      <= cnt_d;
            motor_up_q <= (state_d == MOVE_UP);
            motor_dn_q <= (state_d == MOVE_DN);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign pins_io.motor_up = motor_up_q;
    assign pins_io.motor_dn = motor_dn_q;
    assign pins_io.fault    = fault_q;
    assign pins_io.state_o  = state_q;

endmodule

// File: tb/tb_door_supervisor.sv
// tb_door_supervisor: directed-vector bench for door_supervisor with hand-computed expectations
module tb_door_supervisor;
    import door_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    door_if dif ();

    door_supervisor #(
        .TIMEOUT_CYC(40), .DEB_CYC(4), .REV_PAUSE(8), .AUTO_CLOSE_CYC(500), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .pins_io(dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic w, input logic r, input int n);
        dif.btn_wall   = w;
        dif.btn_remote = r;
        tick(n);
        dif.btn_wall   = 1'b0;
        dif.btn_remote = 1'b0;
        tick(1);
    endtask

    initial begin
        dif.btn_wall = 0; dif.btn_remote = 0; dif.obstruct = 0;
        dif.up_limit = 1; dif.dn_limit = 0; dif.fault_clr = 0;
        tick(4);
        check("rst_state", dif.state_o, ST_INIT);
        check("rst_mup", dif.motor_up, 0);
        check("rst_mdn", dif.motor_dn, 0);
        check("rst_fault", dif.fault, 0);
        rst = 1'b0;
        tick(3);
        check("init_top", dif.state_o, ST_AT_TOP);
        check("top_mup", dif.motor_up, 0);
        check("top_mdn", dif.motor_dn, 0);
        check("top_fault", dif.fault, 0);

        dif.btn_wall = 1;
        tick(6);
        dif.btn_wall = 0;
        check("deb_not_early", dif.state_o, ST_AT_TOP);
        tick(1);
        check("close_state", dif.state_o, ST_MOVE_DN);
        check("close_mdn", dif.motor_dn, 1);
        check("close_mup", dif.motor_up, 0);
        dif.up_limit = 0;
        dif.dn_limit = 1;
        tick(2);
        check("dnlim_lat2", dif.motor_dn, 1);
        tick(1);
        check("dnlim_lat3", dif.motor_dn, 0);
        check("at_bot", dif.state_o, ST_AT_BOT);

        press(1, 1, 6);
        dif.dn_limit = 0;
        check("both_move", dif.state_o, ST_MOVE_UP);
        check("both_mup", dif.motor_up, 1);
        tick(3);
        check("both_single", dif.state_o, ST_MOVE_UP);

        press(0, 1, 6);
        check("remote_stop", dif.state_o, ST_STOPPED);
        check("stop_mup", dif.motor_up, 0);
        check("stop_mdn", dif.motor_dn, 0);
        press(1, 0, 6);
        check("resume_dn", dif.motor_dn, 1);
        check("resume_state", dif.state_o, ST_MOVE_DN);

        dif.obstruct = 1;
        tick(2);
        dif.obstruct = 0;
        check("obs_lat2", dif.state_o, ST_MOVE_DN);
        tick(1);
        check("pause_state", dif.state_o, ST_PAUSE);
        check("pause_mdn", dif.motor_dn, 0);
        check("pause_mup", dif.motor_up, 0);
        tick(7);
        check("pause_last", dif.state_o, ST_PAUSE);
        tick(1);
        check("reverse_up", dif.motor_up, 1);
        check("reverse_state", dif.state_o, ST_MOVE_UP);
        dif.up_limit = 1;
        tick(2);
        check("uplim_lat2", dif.state_o, ST_MOVE_UP);
        tick(1);
        check("uplim_top", dif.state_o, ST_AT_TOP);
        check("uplim_mup", dif.motor_up, 0);

        dif.up_limit = 0;
        press(1, 0, 6);
        check("to_dn", dif.state_o, ST_MOVE_DN);
        press(1, 0, 6);
        check("to_stop", dif.state_o, ST_STOPPED);
        press(1, 0, 6);
        check("to_up", dif.state_o, ST_MOVE_UP);
        tick(39);
        check("to_last_up", dif.motor_up, 1);
        tick(1);
        check("to_fault_state", dif.state_o, ST_FAULT);
        check("to_fault", dif.fault, 1);
        check("to_mup", dif.motor_up, 0);
        check("to_mdn", dif.motor_dn, 0);
        press(1, 1, 6);
        tick(2);
        check("fault_ignores_req", dif.state_o, ST_FAULT);
        dif.up_limit = 1;
        dif.fault_clr = 1;
        tick(1);
        dif.fault_clr = 0;
        tick(2);
        check("clr_init", dif.state_o, ST_INIT);
        check("clr_fault", dif.fault, 0);
        tick(1);
        check("clr_top", dif.state_o, ST_AT_TOP);

        press(1, 0, 2);
        tick(10);
        check("bounce", dif.state_o, ST_AT_TOP);

        press(1, 0, 6);
        check("pre_rst_mdn", dif.motor_dn, 1);
        #2 rst = 1'b1;
        #1 check("async_rst_mdn", dif.motor_dn, 0);
        check("async_rst_state", dif.state_o, ST_INIT);
        dif.up_limit = 0;
        dif.dn_limit = 1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reinit_bot", dif.state_o, ST_AT_BOT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/door_supervisor.md
Name: door_supervisor

Overview:
Safety and sequencing controller for a single garage-door motor. It merges two requesters (wall button, remote) into one request stream and drives the motor up/down outputs. It also enforces limit-switch stops, obstruction auto-reverse, a travel timeout and a latched fault. It sits between raw board inputs and the motor driver pins.

Parameters:
TIMEOUT_CYC, 1000, max cycles in a MOVE_* state before a limit is reached; exceeding it is a fault
DEB_CYC, 4, consecutive synchronized-high cycles a button must hold to count as a press
REV_PAUSE, 8, motor-off cycles between obstruction detection and upward reversal
AUTO_CLOSE_CYC, 500, idle cycles in AT_TOP before auto-close (used only with AUTO_CLOSE_EN)
CNT_W, 16, width of the shared timer counter; every *_CYC parameter must be less than 2**CNT_W

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
btn_wall  in  1  wall button, asynchronous raw level
btn_remote  in  1  remote receiver output, asynchronous raw level
obstruct  in  1  beam-break sensor, 1 = blocked, asynchronous
up_limit  in  1  door fully up, asynchronous
dn_limit  in  1  door fully down, asynchronous
fault_clr  in  1  synchronous pulse that clears a latched fault
motor_up  out  1  drive motor upward, registered
motor_dn  out  1  drive motor downward, registered
fault  out  1  latched fault indication, registered
state_o  out  3  current state code, registered

Behaviour:
- Synchronization: every asynchronous input passes through a 2-flop synchronizer. Limit/obstruct to motor change latency is exactly 3 rising edges after the input is first sampled (2 sync + 1 state).
- Requests: each button has its own debounce. A press is registered when the synced level is high for DEB_CYC consecutive cycles. The debounce emits one 1-cycle pulse per press; no repeat pulse until the level returns low.
- Request arbitration: req = OR of both pulses. Same-cycle pulses count as a single request.
- Reset values: motor_up=0, motor_dn=0, fault=0, state_o=INIT, counter=0, last_dir=DN.
- State codes: INIT=0, AT_TOP=1, AT_BOT=2, MOVE_UP=3, MOVE_DN=4, STOPPED=5, PAUSE=6, FAULT=7.
- INIT:
  - up&dn both high -> FAULT
  - up only -> AT_TOP
  - dn only -> AT_BOT
  - neither -> STOPPED with last_dir=DN, so the next request raises the door
- AT_TOP: req -> MOVE_DN.
- AT_BOT: req -> MOVE_UP.
- MOVE_DN transitions, in priority order:
  - dn_limit -> AT_BOT
  - obstruct -> PAUSE
  - counter reaches TIMEOUT_CYC -> FAULT
  - req -> STOPPED, last_dir=DN
- MOVE_UP transitions, in priority order:
  - up_limit -> AT_TOP
  - timeout -> FAULT
  - req -> STOPPED, last_dir=UP
  - obstruct is ignored while moving up
- STOPPED: req -> move opposite to last_dir.
- PAUSE:
  - motors off for REV_PAUSE cycles, then MOVE_UP
  - requests ignored
  - obstruct is not re-evaluated
- FAULT:
  - fault=1, motors off, all requests ignored
  - fault_clr -> INIT
- Counter: cleared on every state entry; increments while in MOVE_*, PAUSE and (with the optional feature) AT_TOP.
- Output decoding:
  - motor_up=1 only in MOVE_UP; motor_dn=1 only in MOVE_DN.
  - Both outputs are never high in the same cycle.
  - Every direction change passes through at least one motor-off cycle (AT_*, STOPPED or PAUSE).
- Reset mid-travel: motors drop immediately (asynchronous), then re-initialize from the limits as in INIT.

Optional Feature:
- Macro: DOOR_AUTO_CLOSE_EN.
- Defined: in AT_TOP, counter reaching AUTO_CLOSE_CYC with no obstruct -> MOVE_DN. An obstruct while in AT_TOP clears the counter; req still closes immediately.
- Undefined: AT_TOP waits for req indefinitely; AUTO_CLOSE_CYC is unused.

Decomposition:
- Package door_pkg holds:
  - state enum typedef with the 3-bit codes above
  - dir_t (UP=1, DN=0)
  - the state_o code constants, shared with benches
- Sub-module door_debounce (2-flop sync + DEB_CYC counter + single-pulse generation), instantiated once per button.
- Limits, obstruct and fault_clr use plain 2-flop syncs in the top level.

Test Plan:
- Reset released with up_limit=1, dn_limit=0 -> state_o=1 within 3 edges; motor_up=motor_dn=fault=0.
- AT_TOP, btn_wall held 6 cycles -> single motor_dn pulse train starts, state_o=4. Drop up_limit, raise dn_limit -> motor_dn=0 exactly 3 edges later, state_o=2.
- MOVE_DN, obstruct held 2 cycles -> motors 0 and state_o=6 for exactly REV_PAUSE=8 cycles, then motor_up=1. Raise up_limit -> state_o=1.
- Mid-travel in MOVE_UP, press remote -> state_o=5, motors 0. Press wall -> motor_dn=1.
- TIMEOUT_CYC=40, MOVE_UP with no limit -> after 40 cycles fault=1, state_o=7, motors 0. Button presses ignored; fault_clr -> INIT, then resolved by limits.
- Both buttons pressed in the same cycle from AT_BOT -> exactly one move to MOVE_UP. A 2-cycle bounce (below DEB_CYC=4) causes no state change.
